// File: rtl/data_ram_resp_pkg.sv
// rtl/data_ram_resp_pkg.sv - shared constants and mask helpers for the CPU data-memory responder
package data_ram_resp_pkg;

  localparam int PC_WIDTH = 32;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  function automatic logic mask_is_legal(input logic [3:0] m);
    case (m)
      MASK_B0, MASK_B1, MASK_B2, MASK_B3,
      MASK_H0, MASK_H1, MASK_W: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_resp_lane_fmt.sv
// rtl/data_ram_resp_lane_fmt.sv - lane extraction and sign/zero extension of a 32-bit memory word
module ram_lane_fmt
  import data_ram_resp_pkg::*;
(
  input  logic [31:0] word,
  input  logic [3:0]  mask,
  input  logic        sign_ext,
  output logic [31:0] fmt,
  output logic        legal
);

  always_comb begin
    legal = mask_is_legal(mask);
    fmt   = '0;
    case (mask)
      MASK_B0: fmt = {{24{sign_ext & word[7]}},  word[7:0]};
      MASK_B1: fmt = {{24{sign_ext & word[15]}}, word[15:8]};
      MASK_B2: fmt = {{24{sign_ext & word[23]}}, word[23:16]};
      MASK_B3: fmt = {{24{sign_ext & word[31]}}, word[31:24]};
      MASK_H0: fmt = {{16{sign_ext & word[15]}}, word[15:0]};
      MASK_H1: fmt = {{16{sign_ext & word[31]}}, word[31:16]};
      MASK_W:  fmt = word;
      default: fmt = '0;
    endcase
  end

endmodule

// File: rtl/data_ram_resp.sv
// rtl/data_ram_resp.sv - CPU data-memory responder: masked writes, formatted 1-cycle reads, loader, counters, error flag
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    mask,
  input  logic          sign_ext,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [CW-1:0] rd_cnt,
  output logic [CW-1:0] wr_cnt,
  output logic          err
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic          err_q, err_d;

  logic [DW-1:0] fmt_word;
  logic          legal;
  logic          wr_ok, rd_ok;

  // Formatting reads the pre-edge array, so same-cycle loader writes are not visible
  ram_lane_fmt u_fmt (
    .word     (mem_q[addr]),
    .mask     (mask),
    .sign_ext (sign_ext),
    .fmt      (fmt_word),
    .legal    (legal)
  );

  always_comb begin
    wr_ok = we & legal;
    rd_ok = re & ~we & legal;

    mem_d = mem_q;
    // Loader first so the CPU's masked lanes overlay it on an address collision
    if (ld_we) mem_d[ld_addr] = ld_data;
    if (wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem_d[addr][8*i +: 8] = wdata[8*i +: 8];
      end
    end

    rdata_d  = rd_ok ? fmt_word : rdata_q;
    rd_cnt_d = (rd_ok && rd_cnt_q != '1) ? rd_cnt_q + 1'b1 : rd_cnt_q;
    wr_cnt_d = (wr_ok && wr_cnt_q != '1) ? wr_cnt_q + 1'b1 : wr_cnt_q;
    err_d    = err_q | ((re | we) & ~legal) | (re & we);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rdata_q  <= rdata_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
    end
  end

  assign rdata  = rdata_q;
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
  assign err    = err_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// tb/tb_data_ram_resp.sv - directed self-checking bench for data_ram_resp with a behavioural memory model
module tb_data_ram_resp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          re = 1'b0, we = 1'b0, sign_ext = 1'b0, ld_we = 1'b0;
  logic [AW-1:0] addr = '0, ld_addr = '0;
  logic [3:0]    mask = '0;
  logic [DW-1:0] wdata = '0, ld_data = '0;
  logic [DW-1:0] rdata;
  logic [CW-1:0] rd_cnt, wr_cnt;
  logic          err;

  data_ram_resp #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .mask(mask),
    .sign_ext(sign_ext), .wdata(wdata), .rdata(rdata),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] m_mem [1 << AW];
  logic [31:0] m_rdata;
  int          m_rd, m_wr;
  logic        m_err;
  int          n_vec = 0;
  int          n_err = 0;
  bit          chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
    m_rdata = '0;
    m_rd = 0;
    m_wr = 0;
    m_err = 1'b0;
  endtask

  function automatic bit m_legal(input logic [3:0] m);
    return m inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
  endfunction

  // Shift the lowest selected byte to bit 0, then extend from the top selected bit
  function automatic logic [31:0] m_fmt(input logic [31:0] w, input logic [3:0] m, input logic sx);
    int lo = 0;
    int n = 0;
    logic [31:0] v;
    logic sb;
    for (int i = 0; i < 4; i++) if (m[i]) begin
      if (n == 0) lo = i;
      n++;
    end
    v = w >> (8 * lo);
    if (n < 4) begin
      sb = v[8*n-1];
      for (int b = 8 * n; b < 32; b++) v[b] = sx & sb;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("rdata", rdata, m_rdata);
      check("rd_cnt", {28'b0, rd_cnt}, 32'(m_rd));
      check("wr_cnt", {28'b0, wr_cnt}, 32'(m_wr));
      check("err", {31'b0, err}, {31'b0, m_err});
    end
  end

  task automatic cyc(input logic r, input logic w, input logic [AW-1:0] a, input logic [3:0] m,
                     input logic sx, input logic [31:0] wd,
                     input logic lw, input logic [AW-1:0] la, input logic [31:0] ld);
    logic [31:0] rv;
    bit ok;
    @(negedge clk);
    re = r; we = w; addr = a; mask = m; sign_ext = sx; wdata = wd;
    ld_we = lw; ld_addr = la; ld_data = ld;
    @(posedge clk);
    ok = m_legal(m);
    rv = m_fmt(m_mem[a], m, sx);
    if (lw) m_mem[la] = ld;
    if (w && ok) begin
      for (int i = 0; i < 4; i++) if (m[i]) m_mem[a][8*i +: 8] = wd[8*i +: 8];
      if (m_wr < CNT_MAX) m_wr++;
    end
    if (r && !w && ok) begin
      m_rdata = rv;
      if (m_rd < CNT_MAX) m_rd++;
    end
    if (((r || w) && !ok) || (r && w)) m_err = 1'b1;
    #1;
    re = 0; we = 0; ld_we = 0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [3:0] m, input logic sx);
    cyc(1, 0, a, m, sx, 32'h0, 0, '0, 32'h0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_rd_cnt", {28'b0, rd_cnt}, 32'h0);
    check("reset_wr_cnt", {28'b0, wr_cnt}, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);
    chk_on = 1;

    cyc(0, 0, 5'd0, 4'h0, 0, 32'h0, 1, 5'd3, 32'h8081_7F80);
    rd(5'd3, 4'hF, 0);
    check("lit_word_read", rdata, 32'h8081_7F80);
    check("lit_rd_cnt1", {28'b0, rd_cnt}, 32'd1);
    rd(5'd3, 4'h1, 1);
    check("lit_b0_sx", rdata, 32'hFFFF_FF80);
    rd(5'd3, 4'h2, 1);
    check("lit_b1_sx", rdata, 32'h0000_007F);
    rd(5'd3, 4'hC, 0);
    check("lit_h1_zx", rdata, 32'h0000_8081);
    rd(5'd3, 4'hC, 1);
    check("lit_h1_sx", rdata, 32'hFFFF_8081);
    rd(5'd3, 4'h8, 0);
    check("lit_b3_zx", rdata, 32'h0000_0080);

    cyc(0, 1, 5'd3, 4'h4, 0, 32'h00AA_0000, 0, '0, 32'h0);
    rd(5'd3, 4'hF, 0);
    check("lit_raw", rdata, 32'h80AA_7F80);
    check("lit_wr_cnt1", {28'b0, wr_cnt}, 32'd1);
    cyc(0, 0, 5'd3, 4'hF, 0, 32'h0, 0, '0, 32'h0);
    check("lit_idle_hold", rdata, 32'h80AA_7F80);

    rd(5'd3, 4'h6, 0);
    check("lit_illegal_hold", rdata, 32'h80AA_7F80);
    check("lit_illegal_rd_cnt", {28'b0, rd_cnt}, 32'd7);
    check("lit_illegal_err", {31'b0, err}, 32'd1);
    cyc(0, 1, 5'd3, 4'h0, 0, 32'hFFFF_FFFF, 0, '0, 32'h0);
    rd(5'd3, 4'hF, 0);
    check("lit_mask0_no_write", rdata, 32'h80AA_7F80);

    @(negedge clk);
    chk_on = 0;
    we = 1; addr = 5'd3; mask = 4'hF; wdata = 32'hCAFE_F00D;
    #2 rst = 1;
    #1;
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_rd_cnt", {28'b0, rd_cnt}, 32'h0);
    check("midrst_wr_cnt", {28'b0, wr_cnt}, 32'h0);
    check("midrst_err", {31'b0, err}, 32'h0);
    model_reset();
    @(negedge clk);
    we = 0;
    rst = 0;
    @(posedge clk);
    #1 chk_on = 1;
    rd(5'd3, 4'hF, 0);
    check("lit_after_rst", rdata, 32'h0);

    cyc(1, 1, 5'd3, 4'hF, 0, 32'h1234_5678, 0, '0, 32'h0);
    check("lit_rewe_hold", rdata, 32'h0);
    check("lit_rewe_err", {31'b0, err}, 32'd1);
    rd(5'd3, 4'hF, 0);
    check("lit_rewe_word", rdata, 32'h1234_5678);

    cyc(0, 1, 5'd5, 4'h3, 0, 32'h0000_1111, 1, 5'd5, 32'hFFFF_FFFF);
    rd(5'd5, 4'hF, 0);
    check("lit_ld_cpu_overlay", rdata, 32'hFFFF_1111);

    cyc(1, 0, 5'd7, 4'hF, 0, 32'h0, 1, 5'd7, 32'hDEAD_BEEF);
    check("lit_ld_read_pre", rdata, 32'h0);
    rd(5'd7, 4'h3, 1);
    check("lit_ld_read_post", rdata, 32'hFFFF_BEEF);

    for (int k = 0; k < 20; k++) rd(5'(k), 4'(1 << (k % 4)), 1'(k % 2));
    check("lit_rd_cnt_sat", {28'b0, rd_cnt}, 32'd15);
    check("lit_err_sticky", {31'b0, err}, 32'd1);

    @(negedge clk);
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
